muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit for the execute stage of the five-stage pipeline.
- Replaces the multiply-only multicycle path with one shared datapath covering signed/unsigned multiply and divide.
- Fixed latency, explicit start/busy/done handshake, pipeline flush.
- Results go to HI/LO through the EXE->MEM bus; EXE stage holds `EXE_over` low until `done`.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding, datapath step modes and the operand magnitude helper.
package muldiv_pkg;

    // Operation codes as presented on the op input.
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Behaviour of the shared one-iteration datapath.
    typedef enum logic {
        STEP_MUL = 1'b0,  // add-shift
        STEP_DIV = 1'b1   // subtract-compare-shift
    } step_mode_t;

    // Widest operand md_abs can handle; WIDTH of the unit must not exceed it.
    localparam int MD_MAX_W = 64;

    typedef struct packed {
        logic                neg;
        logic [MD_MAX_W-1:0] mag;
    } md_abs_t;

    // Magnitude and sign of a width-bit operand held zero-extended in val.
    // Only the low width bits of mag are meaningful; the two's-complement
    // negation is correct there regardless of what the upper bits hold.
    function automatic md_abs_t md_abs(input logic [MD_MAX_W-1:0] val,
                                       input int                  width,
                                       input logic                is_signed);
        md_abs_t r;
        r.neg = is_signed & val[width-1];
        r.mag = r.neg ? (~val + MD_MAX_W'(1)) : val;
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath. In multiply mode it
// adds the multiplicand when the current multiplier bit is set and shifts the
// accumulator right; in divide mode it shifts the remainder left, trial-
// subtracts the divisor and shifts the resulting quotient bit in.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  step_mode_t       mode,
    input  logic [WIDTH:0]   upper,       // accumulator high half / remainder
    input  logic [WIDTH-1:0] lower,       // multiplier bits / dividend-quotient
    input  logic [WIDTH-1:0] operand,     // multiplicand / divisor
    output logic [WIDTH:0]   next_upper,
    output logic [WIDTH-1:0] next_lower
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // Single iteration, selected by mode.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_upper = upper;
        next_lower = lower;

        // The accumulator high half never has bit WIDTH set in multiply mode,
        // so adding the full register equals adding its low WIDTH bits.
        sum     = upper + (lower[0] ? {1'b0, operand} : '0);
        shifted = {upper[WIDTH-1:0], lower[WIDTH-1]};
        fits    = (shifted >= {1'b0, operand});
        diff    = shifted - {1'b0, operand};

        if (mode == STEP_MUL) begin
            next_upper = {1'b0, sum[WIDTH:1]};
            next_lower = {sum[0], lower[WIDTH-1:1]};
        end else begin
            next_upper = fits ? diff : shifted;
            next_lower = {lower[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply and divide unit with a fixed latency of
// WIDTH+2 cycles from accepted start to the done pulse. Operands are reduced
// to magnitudes on acceptance, processed by muldiv_step one bit per cycle,
// and re-signed in a single SIGN cycle before the results are published.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_mag;      // |src1|, kept for the divide-by-zero result
    logic [WIDTH-1:0] b_mag;      // |src2|
    logic             sign_q;     // sign of product / quotient
    logic             sign_r;     // sign of remainder (sign of dividend)
    logic [WIDTH:0]   work_hi;
    logic [WIDTH-1:0] work_lo;

    md_abs_t          abs1;
    md_abs_t          abs2;
    logic             is_div;
    step_mode_t       step_mode;
    logic [WIDTH-1:0] step_operand;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_dbz;

    // Operand magnitudes for acceptance; MULT and DIV treat operands as signed.
    always_comb begin
        abs1 = md_abs(MD_MAX_W'(src1), WIDTH, (op == MD_MULT) || (op == MD_DIV));
        abs2 = md_abs(MD_MAX_W'(src2), WIDTH, (op == MD_MULT) || (op == MD_DIV));
    end

    // Step datapath operand routing from the latched operation.
    always_comb begin
        is_div       = (op_q == MD_DIV) || (op_q == MD_DIVU);
        step_mode    = is_div ? STEP_DIV : STEP_MUL;
        step_operand = is_div ? b_mag : a_mag;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode       (step_mode),
        .upper      (work_hi),
        .lower      (work_lo),
        .operand    (step_operand),
        .next_upper (step_hi),
        .next_lower (step_lo)
    );

    // Re-sign the magnitude results, or apply the divide-by-zero rule.
    always_comb begin
        product = {work_hi[WIDTH-1:0], work_lo};
        res_dbz = is_div && (b_mag == '0);
        if (!is_div) begin
            {res_hi, res_lo} = sign_q ? (~product + 1'b1) : product;
        end else if (res_dbz) begin
            res_lo = '1;
            // Re-signing |src1| with its own sign recovers src1 as given.
            res_hi = sign_r ? (~a_mag + 1'b1) : a_mag;
        end else begin
            res_lo = sign_q ? (~work_lo + 1'b1) : work_lo;
            res_hi = sign_r ? (~work_hi[WIDTH-1:0] + 1'b1) : work_hi[WIDTH-1:0];
        end
    end

    // FSM, iteration counter, working registers and published results.
    always_ff @(posedge clk) begin
        // NOTE: all state in this block uses non-blocking assignment so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            op_q        <= MD_MULT;
            a_mag       <= '0;
            b_mag       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            work_hi     <= '0;
            work_lo     <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            // Abort: results keep the values from the last completed operation.
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_mag   <= abs1.mag[WIDTH-1:0];
                        b_mag   <= abs2.mag[WIDTH-1:0];
                        sign_q  <= abs1.neg ^ abs2.neg;
                        sign_r  <= abs1.neg;
                        cnt     <= '0;
                        work_hi <= '0;
                        // Multiply walks the multiplier; divide walks the dividend.
                        work_lo <= op[1] ? abs1.mag[WIDTH-1:0] : abs2.mag[WIDTH-1:0];
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    div_by_zero <= res_dbz;
                    state       <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A flush or reset landing in DONE cancels that cycle's pulse.
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE) && !flush && !reset;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with literal results,
// then randomized start/flush/reset traffic compared every cycle against a
// behavioural model built from integer arithmetic and a latency countdown.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] src1  = '0;
    logic [W-1:0] src2  = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src1        (src1),
        .src2        (src2),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference results from plain integer arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l, output logic z);
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        longint      sa;
        longint      sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            MD_MULT: begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
            end
            MD_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                h = p[63:32];
                l = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                    z = 1'b1;
                end else if (o == MD_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    // Behavioural model: cycles left until idle, plus expected published results.
    int           remaining = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dbz = 1'b0;
    logic [W-1:0] pend_hi;
    logic [W-1:0] pend_lo;
    logic         pend_dbz;
    bit           armed = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            remaining = 0;
            exp_hi    = '0;
            exp_lo    = '0;
            exp_dbz   = 1'b0;
            armed     = 1'b1;
        end else if (flush) begin
            remaining = 0;
        end else if (remaining == 0) begin
            if (start) begin
                remaining = W + 2;
                ref_model(op, src1, src2, pend_hi, pend_lo, pend_dbz);
            end
        end else begin
            if (remaining == 2) begin
                exp_hi  = pend_hi;
                exp_lo  = pend_lo;
                exp_dbz = pend_dbz;
            end
            remaining--;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            check("cyc_busy", 64'(busy), 64'(remaining != 0));
            check("cyc_done", 64'(done), 64'((remaining == 1) && !flush && !reset));
            check("cyc_hi",   64'(hi),   64'(exp_hi));
            check("cyc_lo",   64'(lo),   64'(exp_lo));
            check("cyc_dbz",  64'(div_by_zero), 64'(exp_dbz));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 8)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return W'($urandom);
        endcase
    endfunction

    // Issue one operation once idle and wait (bounded) for its done pulse.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz,
                         output int lat);
        int n;
        bit got;
        n = 0;
        tick();
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (busy) check("idle_wait", 64'(busy), 64'(0));
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        tick();
        start = 1'b0;
        op    = 2'($urandom);
        src1  = W'($urandom);
        src2  = W'($urandom);
        lat   = 0;
        got   = 1'b0;
        rh    = '0;
        rl    = '0;
        rz    = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) begin
                got = 1'b1;
                rh  = hi;
                rl  = lo;
                rz  = div_by_zero;
            end
        end
        if (!got) check("done_timeout", 64'(got), 64'(1));
    endtask

    logic [W-1:0] rh;
    logic [W-1:0] rl;
    logic         rz;
    int           lat;
    int           ndone;

    initial begin
        // Pin the model with hand-computed values.
        ref_model(MD_MULT, 32'hFFFF_FFF9, 32'd3, rh, rl, rz);
        check("model_mult_hi", 64'(rh), 64'hFFFF_FFFF);
        check("model_mult_lo", 64'(rl), 64'hFFFF_FFEB);
        ref_model(MD_DIV, 32'd7, 32'hFFFF_FFFE, rh, rl, rz);
        check("model_div_q", 64'(rl), 64'hFFFF_FFFD);
        check("model_div_r", 64'(rh), 64'h1);

        // Reset state.
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi",   64'(hi),   64'(0));
        check("rst_lo",   64'(lo),   64'(0));
        check("rst_dbz",  64'(div_by_zero), 64'(0));
        reset = 1'b0;

        // Directed operations.
        do_op(MD_MULT, 32'hFFFF_FFFF, 32'h2, rh, rl, rz, lat);
        check("mult_hi", 64'(rh), 64'hFFFF_FFFF);
        check("mult_lo", 64'(rl), 64'hFFFF_FFFE);
        check("mult_latency", 64'(lat), 64'd34);

        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'h2, rh, rl, rz, lat);
        check("multu_hi", 64'(rh), 64'h1);
        check("multu_lo", 64'(rl), 64'hFFFF_FFFE);
        check("multu_dbz", 64'(rz), 64'h0);

        do_op(MD_DIV, 32'hFFFF_FFF9, 32'h2, rh, rl, rz, lat);
        check("div_q", 64'(rl), 64'hFFFF_FFFD);
        check("div_r", 64'(rh), 64'hFFFF_FFFF);

        do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, rz, lat);
        check("div_ovf_q", 64'(rl), 64'h8000_0000);
        check("div_ovf_r", 64'(rh), 64'h0);
        check("div_ovf_dbz", 64'(rz), 64'h0);

        do_op(MD_DIVU, 32'd7, 32'd0, rh, rl, rz, lat);
        check("divu0_lo", 64'(rl), 64'hFFFF_FFFF);
        check("divu0_hi", 64'(rh), 64'h7);
        check("divu0_dbz", 64'(rz), 64'h1);
        check("divu0_latency", 64'(lat), 64'd34);

        do_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, rh, rl, rz, lat);
        check("div0_hi", 64'(rh), 64'hFFFF_FFF9);
        check("div0_dbz", 64'(rz), 64'h1);

        do_op(MD_MULTU, 32'd3, 32'd5, rh, rl, rz, lat);
        check("multu35_lo", 64'(rl), 64'd15);
        check("multu35_dbz", 64'(rz), 64'h0);

        // Flush 10 cycles into a DIVU: no done, idle next cycle, results held.
        tick();
        start = 1'b1; op = MD_DIVU; src1 = 32'd100; src2 = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_lo", 64'(lo), 64'd15);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush_no_done", 64'(ndone), 64'd0);

        // A start pulsed while busy is ignored.
        tick();
        start = 1'b1; op = MD_MULTU; src1 = 32'd6; src2 = 32'd7;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1; op = MD_MULT; src1 = 32'd9; src2 = 32'd9;
        tick();
        start = 1'b0;
        ndone = 0;
        rl    = '0;
        repeat (80) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                rl = lo;
            end
        end
        check("busy_start_ndone", 64'(ndone), 64'd1);
        check("busy_start_lo", 64'(rl), 64'd42);

        // Reset during CALC, then an immediate new operation.
        tick();
        start = 1'b1; op = MD_DIV; src1 = 32'd1000; src2 = 32'hFFFF_FFFD;
        tick();
        start = 1'b0;
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hi",   64'(hi),   64'(0));
        check("midrst_lo",   64'(lo),   64'(0));
        check("midrst_dbz",  64'(div_by_zero), 64'(0));
        do_op(MD_MULTU, 32'd1000, 32'd1000, rh, rl, rz, lat);
        check("postrst_lo", 64'(rl), 64'h000F_4240);
        check("postrst_hi", 64'(rh), 64'h0);
        check("postrst_latency", 64'(lat), 64'd34);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 3) == 0;
            op    = 2'($urandom);
            src1  = pick();
            src2  = pick();
            flush = ($urandom % 40) == 0;
            reset = ($urandom % 500) == 0;
            tick();
        end
        start = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        repeat (50) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
